dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder on the datapath's load/store port. It accepts one request at a time (`addr`, `wdata`, `we`, `size`), holds it for a programmable number of wait states, then completes it with a one-cycle `ready` pulse. It returns read data or commits write data at completion. While a request is outstanding, `busy` serves as the stall input to the processor's PC/writeback enables.

## Interface
Parameters:
- `DEPTH`, default 64: number of 32-bit words of storage. Power of two, ≥4.
- `WAIT_CYCLES`, default 2: wait states between accept and completion, range 0–15.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `req`, input, 1: access request (`MemWrite | MemRead` from control).
- `we`, input, 1: 1 = store, 0 = load. Sampled at accept.
- `size`, input, 1: 0 = word (LDR/STR), 1 = byte (LDRB/STRB). Sampled at accept.
- `addr`, input, 32: byte address (`ALUResult`). Sampled at accept.
- `wdata`, input, 32: store data (`WriteData`). Sampled at accept.
- `rdata`, output, 32: load data (`ReadData`). Valid only when `ready`=1.
- `ready`, output, 1: one-cycle completion pulse.
- `err`, output, 1: qualifies `ready`; access was rejected.
- `busy`, output, 1: request accepted and not yet completed.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE: if `req`=1, latch `we`, `size`, `addr`, `wdata` and set `busy`.
  - Go to WAIT with count = `WAIT_CYCLES`-1 when `WAIT_CYCLES`>0.
  - Go directly to RESP when `WAIT_CYCLES`=0.
- WAIT: decrement the counter each cycle. Go to RESP when the counter reaches 0.
- RESP: assert `ready` for exactly this cycle, then return to IDLE unconditionally.
  - `req` seen during RESP is not accepted.
  - A `req` still high in the following IDLE cycle is accepted as a new access, so back-to-back accesses have one idle cycle between them.
- Input changes after accept are ignored. Only the latched copy is used.
- Word index = `addr[31:2]`. Byte lane = `addr[1:0]`, little-endian: lane 0 = bits 7:0.
- Error conditions, evaluated on the latched request:
  - word access with `addr[1:0]` ≠ 0;
  - `addr[31:2]` ≥ `DEPTH`.
- On error: `ready`=1, `err`=1, `rdata`=0, storage unchanged.
- Word load: `rdata` = mem[index].
- Byte load: `rdata` = {24'b0, selected byte}, zero-extended.
- Word store: mem[index] ← `wdata`, on the rising edge ending the RESP cycle.
- Byte store: only the addressed byte ← `wdata[7:0]`. The other three bytes are unchanged.
- Load during RESP returns storage contents including all previously completed stores.
- Storage contents are not cleared by reset. Power-up contents are undefined, and benches must write before reading.

## Timing
- Reset (async assert, any state):
  - FSM goes to IDLE; the wait counter is cleared.
  - `ready`=0, `err`=0, `busy`=0, `rdata`=0, immediately and without waiting for `clk`.
  - An in-flight store is dropped; its memory word is unchanged.
- Deassertion takes effect at the next `clk` edge. The first accept can occur in the first cycle after deassertion.
- Latency: request accepted at edge E (cycle 0) → `ready` high during cycle `WAIT_CYCLES`+1.
- `busy` is high from cycle 1 through the `ready` cycle inclusive, and low in IDLE.
- `ready`, `err`, and `rdata` are registered outputs, with no combinational path from the inputs.
- Throughput: one access per `WAIT_CYCLES`+2 cycles under continuous `req`.

## Test plan
- Reset, then word store with `WAIT_CYCLES`=2: `addr`=0x10, `wdata`=0xDEADBEEF, `we`=1. Expect `ready` in cycle 3 with `err`=0 and `busy` high in cycles 1–3. A following word load of 0x10 returns 0xDEADBEEF.
- Byte store 0x5A to `addr`=0x13 over stored word 0x11223344. A word load of 0x10 returns 0x5A223344. A byte load of 0x12 returns 0x00000022.
- Misaligned word load at 0x0000_0006 → `ready`=1, `err`=1, `rdata`=0. An out-of-range store to `DEPTH`×4 → `err`=1, and a subsequent load of address 0 shows the word unchanged.
- Hold `req`=1 continuously with alternating store/load: accepts occur every 4 cycles, exactly one `ready` pulse per access, and `we`/`addr` changes during WAIT are ignored.
- Assert `reset` mid-WAIT of a store to 0x20 (prior value 0xAAAAAAAA). All outputs go to 0 asynchronously; after release, a load of 0x20 returns 0xAAAAAAAA.
- `WAIT_CYCLES`=0 instance: a word load accepted at cycle 0 gives `ready` in cycle 1, and back-to-back accesses are accepted every 2 cycles.

Source files
------------

// File: rtl/dmem_if.sv
// dmem_if: load/store port between the datapath and the data-memory responder
interface dmem_if;
    logic        req;
    logic        we;
    logic        size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;
    modport master(output req, we, size, addr, wdata, input rdata, ready, err, busy);
    modport slave(input req, we, size, addr, wdata, output rdata, ready, err, busy);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word/byte data memory with programmable wait states
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input logic   clk,
    input logic   reset,
    dmem_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        we_q, size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] mem [DEPTH];

    logic        accept;
    logic [31:0] a_addr;
    logic        a_we, a_size, a_err;
    logic [31:0] word;
    logic [7:0]  lane_byte;

    assign accept    = state == IDLE && bus.req;
    assign bus.busy  = state != IDLE;
    // In IDLE the response is built straight from the bus so a zero-wait access can enter RESP on its accept edge
    assign a_addr    = (state == IDLE) ? bus.addr : addr_q;
    assign a_we      = (state == IDLE) ? bus.we : we_q;
    assign a_size    = (state == IDLE) ? bus.size : size_q;
    assign a_err     = (|a_addr[31:IW+2]) || (!a_size && |a_addr[1:0]);
    assign word      = mem[a_addr[IW+1:2]];
    assign lane_byte = word[{a_addr[1:0], 3'b000} +: 8];

    // State and wait counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state: accept in IDLE, count down in WAIT, RESP always returns to IDLE
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (accept) begin
            state_n = (WAIT_CYCLES == 0) ? RESP : WAIT;
            cnt_n   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
        end else if (state == WAIT) begin
            state_n = (cnt == 4'd0) ? RESP : WAIT;
            cnt_n   = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
        end else if (state == RESP) begin
            state_n = IDLE;
        end
    end

    // Latch the request on accept; later bus changes are ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q    <= 1'b0;
            size_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.we;
            size_q  <= bus.size;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
        end
    end

    // Registered completion: ready/err/rdata are loaded on the edge entering RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ready <= state_n == RESP;
            bus.err   <= state_n == RESP && a_err;
            bus.rdata <= (state_n != RESP || a_err || a_we) ? '0 : a_size ? {24'h0, lane_byte} : word;
        end
    end

    // Commit stores on the edge ending RESP; a reset during RESP leaves IDLE and drops the write
    always_ff @(posedge clk) begin
        if (state == RESP && we_q && !bus.err) begin
            if (size_q) mem[addr_q[IW+1:2]][{addr_q[1:0], 3'b000} +: 8] <= wdata_q[7:0];
            else mem[addr_q[IW+1:2]] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vector table, held-req bursts, reset cases and randomized model check
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   passed = 0;

    dmem_if b0();
    dmem_if b1();

    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        bit          s;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        bit          e;
    } vec_t;

    vec_t        tv[20];
    logic [31:0] ref_mem[16];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", n, act, exp);
    endtask

    task automatic drive(input bit u, input bit r, input bit w, input bit s, input logic [31:0] a, input logic [31:0] d);
        if (u) begin
            b1.req = r; b1.we = w; b1.size = s; b1.addr = a; b1.wdata = d;
        end else begin
            b0.req = r; b0.we = w; b0.size = s; b0.addr = a; b0.wdata = d;
        end
    endtask

    task automatic sample(input bit u, output logic rdy, output logic er, output logic [31:0] rd);
        rdy = u ? b1.ready : b0.ready;
        er  = u ? b1.err : b0.err;
        rd  = u ? b1.rdata : b0.rdata;
    endtask

    // One access on the WAIT_CYCLES=2 instance; scrambles the bus after accept
    task automatic access(input bit w, input bit s, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output bit e, output int lat);
        @(negedge clk);
        chk("ready_low_before_accept", b0.ready, 0);
        drive(0, 1, w, s, a, d);
        @(posedge clk);
        #1 drive(0, 0, ~w, ~s, $urandom, $urandom);
        lat = 0; rd = '0; e = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            chk($sformatf("busy_cycle%0d", k), b0.busy, 1);
            if (b0.ready) begin
                lat = k; rd = b0.rdata; e = b0.err;
                break;
            end
        end
    endtask

    // req held high with alternating store/load; inputs scrambled while not in IDLE
    task automatic burst(input bit u, input int per, input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1);
        logic rdy, er;
        logic [31:0] rd, exp3;
        int k;
        exp3 = (d0 & 32'hFFFF00FF) | ({24'h0, d1[7:0]} << 8);
        for (int j = 0; j <= 4 * per; j++) begin
            @(negedge clk);
            sample(u, rdy, er, rd);
            k = j / per;
            chk($sformatf("burst%0d_ready_j%0d", u, j), rdy, (j % per) == per - 1);
            if (rdy) begin
                chk($sformatf("burst%0d_err_k%0d", u, k), er, 0);
                if (k == 1) chk($sformatf("burst%0d_load1", u), rd, d0);
                if (k == 3) chk($sformatf("burst%0d_load3", u), rd, exp3);
            end
            if (j == 4 * per) drive(u, 0, 0, 0, 0, 0);
            else if (j % per == 0) drive(u, 1, k % 2 == 0, k == 2, (k == 2) ? base + 1 : base, (k == 2) ? d1 : d0);
            else drive(u, 1, 1'($urandom), 1'($urandom), $urandom, $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, a, d, exp;
        bit er, w, s, e;
        int lat, i, l, sel;

        tv[0]  = '{1, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0};
        tv[1]  = '{0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0};
        tv[2]  = '{1, 0, 32'h10, 32'h11223344, 32'h0, 0};
        tv[3]  = '{1, 1, 32'h13, 32'hFFFFFF5A, 32'h0, 0};
        tv[4]  = '{0, 0, 32'h10, 32'h0, 32'h5A223344, 0};
        tv[5]  = '{0, 1, 32'h12, 32'h0, 32'h00000022, 0};
        tv[6]  = '{0, 1, 32'h13, 32'h0, 32'h0000005A, 0};
        tv[7]  = '{0, 0, 32'h06, 32'h0, 32'h0, 1};
        tv[8]  = '{1, 0, 32'h00, 32'h12345678, 32'h0, 0};
        tv[9]  = '{1, 0, 32'h100, 32'hFFFFFFFF, 32'h0, 1};
        tv[10] = '{0, 0, 32'h00, 32'h0, 32'h12345678, 0};
        tv[11] = '{1, 1, 32'h101, 32'h000000EE, 32'h0, 1};
        tv[12] = '{1, 0, 32'h02, 32'hAAAAAAAA, 32'h0, 1};
        tv[13] = '{0, 0, 32'h00, 32'h0, 32'h12345678, 0};
        tv[14] = '{1, 0, 32'hFC, 32'hCAFEF00D, 32'h0, 0};
        tv[15] = '{0, 1, 32'hFE, 32'h0, 32'h000000FE, 0};
        tv[16] = '{0, 0, 32'hFC, 32'h0, 32'hCAFEF00D, 0};
        tv[17] = '{0, 1, 32'h10, 32'h0, 32'h00000044, 0};
        tv[18] = '{0, 1, 32'h11, 32'h0, 32'h00000033, 0};
        tv[19] = '{0, 0, 32'h80000010, 32'h0, 32'h0, 1};

        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        #3;
        chk("rst0_ready", b0.ready, 0); chk("rst0_err", b0.err, 0);
        chk("rst0_busy", b0.busy, 0);   chk("rst0_rdata", b0.rdata, 0);
        chk("rst1_ready", b1.ready, 0); chk("rst1_busy", b1.busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        foreach (tv[n]) begin
            access(tv[n].w, tv[n].s, tv[n].a, tv[n].d, rd, er, lat);
            chk($sformatf("tv%0d_lat", n), lat, 3);
            chk($sformatf("tv%0d_err", n), er, tv[n].e);
            if (!tv[n].w || tv[n].e) chk($sformatf("tv%0d_rdata", n), rd, tv[n].rd);
        end

        burst(0, 4, 32'h40, 32'h0BADF00D, 32'h000000C3);
        burst(1, 2, 32'h08, 32'h13579BDF, 32'h000000EE);

        access(1, 0, 32'h20, 32'hAAAAAAAA, rd, er, lat);
        @(negedge clk);
        drive(0, 1, 1, 0, 32'h20, 32'h55555555);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rstw_busy_pre", b0.busy, 1);
        #2 reset = 1'b0;
        #1;
        chk("rstw_busy", b0.busy, 0);   chk("rstw_ready", b0.ready, 0);
        chk("rstw_err", b0.err, 0);     chk("rstw_rdata", b0.rdata, 0);
        @(negedge clk);
        reset = 1'b1;
        access(0, 0, 32'h20, 32'h0, rd, er, lat);
        chk("rstw_mem_kept", rd, 32'hAAAAAAAA);

        for (int k = 0; k < 2; k++) begin
            access(k == 0, 0, 32'h20, 32'h55555555, rd, er, lat);
            chk($sformatf("rstr%0d_ready_pre", k), b0.ready, 1);
            #1 reset = 1'b0;
            #1;
            chk($sformatf("rstr%0d_ready", k), b0.ready, 0);
            chk($sformatf("rstr%0d_busy", k), b0.busy, 0);
            chk($sformatf("rstr%0d_rdata", k), b0.rdata, 0);
            @(negedge clk);
            reset = 1'b1;
        end
        access(0, 0, 32'h20, 32'h0, rd, er, lat);
        chk("rstr_mem_kept", rd, 32'hAAAAAAAA);

        for (int n = 0; n < 16; n++) begin
            ref_mem[n] = $urandom;
            access(1, 0, n * 4, ref_mem[n], rd, er, lat);
            chk("init_err", er, 0);
        end

        for (int n = 0; n < 60; n++) begin
            w = 1'($urandom); s = 1'($urandom); d = $urandom;
            i = $urandom_range(0, 15); l = $urandom_range(0, 3); sel = $urandom_range(0, 9);
            a = (sel == 0) ? ($urandom | 32'h100) : (sel == 1) ? i * 4 + l : i * 4 + (s ? l : 0);
            e = (a >= 256) || (!s && a % 4 != 0);
            exp = 32'h0;
            if (!e && !w) exp = s ? (ref_mem[a / 4] >> (8 * (a % 4))) & 32'hFF : ref_mem[a / 4];
            if (!e && w) ref_mem[a / 4] = s ? (ref_mem[a / 4] & ~(32'hFF << (8 * (a % 4)))) | ((d & 32'hFF) << (8 * (a % 4))) : d;
            access(w, s, a, d, rd, er, lat);
            chk($sformatf("rnd%0d_lat", n), lat, 3);
            chk($sformatf("rnd%0d_err a=%h", n, a), er, e);
            if (!w || e) chk($sformatf("rnd%0d_rdata a=%h", n, a), rd, exp);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
